forwarding_unit: RTL

Hazard and forwarding controller for the RV32IM 5-stage pipeline. It tracks the destination registers of in-flight instructions in shadow EX/MEM/WB/HOLD entries. It drives the 2-bit selects of the two EX-stage 4:1 operand muxes and raises STALL on load-use hazards. It sits beside the ID/EX pipeline register and is clocked with it.

---
 rtl/fwd_pkg.sv | 28 ++
 rtl/fwd_shadow_stage.sv | 32 +++
 rtl/forwarding_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller.
//   - fwd_sel_e      : 2-bit operand-mux select codes
//   - shadow_entry_t : {valid, rd, reg_write, mem_read} for one in-flight stage
//   - entry_writes() : true when an entry will write a given nonzero register
package fwd_pkg;

  localparam int unsigned FWD_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,  // register-file value
    FWD_EXMEM = 2'b01,  // EX/MEM ALU result
    FWD_MEMWB = 2'b10,  // MEM/WB writeback data
    FWD_HOLD  = 2'b11   // writeback data delayed one cycle
  } fwd_sel_e;

  typedef struct packed {
    logic                      valid;
    logic [FWD_REG_ADDR_W-1:0] rd;
    logic                      reg_write;
    logic                      mem_read;
  } shadow_entry_t;

  // x0 is hard-wired to zero, so it is never a forwarding source.
  function automatic logic entry_writes(shadow_entry_t e, logic [FWD_REG_ADDR_W-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_shadow_stage.sv
// One shadow pipeline entry mirroring an in-flight instruction.
// Ports:
//   CLK      in  clock, rising edge
//   RESET    in  synchronous active-low reset (overrides hold)
//   i_hold   in  keep current contents
//   i_bubble in  load an invalid entry instead of i_d
//   i_d      in  entry from the previous stage
//   o_q      out registered entry
module fwd_shadow_stage
  import fwd_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          i_hold,
  input  logic          i_bubble,
  input  shadow_entry_t i_d,
  output shadow_entry_t o_q
);

  shadow_entry_t r_q;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_q <= '0;
    end else if (!i_hold) begin
      r_q <= i_bubble ? shadow_entry_t'('0) : i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/forwarding_unit.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Tracks destination registers of in-flight instructions, registers the EX
// operand-mux selects, and raises STALL on load-use hazards.
// Optional feature macro: FWD_HOLD_BYPASS_EN (adds the HOLD entry and select 11).
// Ports:
//   CLK, RESET                   clock / synchronous active-low reset
//   ID_VALID                     ID holds a live instruction
//   ID_RS1, ID_RS2               source registers of the ID instruction
//   ID_USES_RS1, ID_USES_RS2     the sources are actually read
//   ID_RD, ID_REG_WRITE          destination and its write enable
//   ID_MEM_READ                  ID instruction is a load
//   FLUSH                        kill the ID instruction (bubble into EX)
//   EXT_HOLD                     global freeze
//   FWD_SEL_A, FWD_SEL_B         registered EX operand-mux selects
//   STALL                        combinational load-use stall
module forwarding_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = FWD_REG_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_VALID,
  input  logic [REG_ADDR_W-1:0] ID_RS1,
  input  logic [REG_ADDR_W-1:0] ID_RS2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic [REG_ADDR_W-1:0] ID_RD,
  input  logic                  ID_REG_WRITE,
  input  logic                  ID_MEM_READ,
  input  logic                  FLUSH,
  input  logic                  EXT_HOLD,
  output logic [1:0]            FWD_SEL_A,
  output logic [1:0]            FWD_SEL_B,
  output logic                  STALL
);

  shadow_entry_t w_id;
  shadow_entry_t w_ex;
  shadow_entry_t w_mem;
  logic          w_lu_a;
  logic          w_lu_b;
  logic          w_stall;
  logic          w_bubble;
  fwd_sel_e      w_sel_a;
  fwd_sel_e      w_sel_b;
  fwd_sel_e      r_sel_a;
  fwd_sel_e      r_sel_b;

  assign w_id = '{valid: ID_VALID, rd: ID_RD, reg_write: ID_REG_WRITE, mem_read: ID_MEM_READ};

  // Load-use: the value a used source needs is still being loaded in EX.
  assign w_lu_a   = ID_USES_RS1 && entry_writes(w_ex, ID_RS1) && w_ex.mem_read;
  assign w_lu_b   = ID_USES_RS2 && entry_writes(w_ex, ID_RS2) && w_ex.mem_read;
  assign w_stall  = RESET && ID_VALID && !FLUSH && !EXT_HOLD && (w_lu_a || w_lu_b);
  assign w_bubble = w_stall || FLUSH;
  assign STALL    = w_stall;

  fwd_shadow_stage u_ex (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_hold   (EXT_HOLD),
    .i_bubble (w_bubble),
    .i_d      (w_id),
    .o_q      (w_ex)
  );

  fwd_shadow_stage u_mem (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_hold   (EXT_HOLD),
    .i_bubble (1'b0),
    .i_d      (w_ex),
    .o_q      (w_mem)
  );

`ifdef FWD_HOLD_BYPASS_EN
  shadow_entry_t w_wb;
  shadow_entry_t w_hold;

  fwd_shadow_stage u_wb (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_hold   (EXT_HOLD),
    .i_bubble (1'b0),
    .i_d      (w_mem),
    .o_q      (w_wb)
  );

  fwd_shadow_stage u_hold (
    .CLK      (CLK),
    .RESET    (RESET),
    .i_hold   (EXT_HOLD),
    .i_bubble (1'b0),
    .i_d      (w_wb),
    .o_q      (w_hold)
  );
`endif
  // Without the bypass the WB entry feeds nothing (write-first register file
  // covers that case), so it is not built.

  // Selects are decided at ID and apply once the instruction reaches EX, so
  // each entry maps to where its producer will sit one cycle later.
  always_comb begin
    w_sel_a = FWD_RF;
    if (ID_USES_RS1) begin
      if (entry_writes(w_ex, ID_RS1) && !w_ex.mem_read) w_sel_a = FWD_EXMEM;
      else if (entry_writes(w_mem, ID_RS1))             w_sel_a = FWD_MEMWB;
`ifdef FWD_HOLD_BYPASS_EN
      else if (entry_writes(w_wb, ID_RS1))              w_sel_a = FWD_HOLD;
`endif
    end
  end

  always_comb begin
    w_sel_b = FWD_RF;
    if (ID_USES_RS2) begin
      if (entry_writes(w_ex, ID_RS2) && !w_ex.mem_read) w_sel_b = FWD_EXMEM;
      else if (entry_writes(w_mem, ID_RS2))             w_sel_b = FWD_MEMWB;
`ifdef FWD_HOLD_BYPASS_EN
      else if (entry_writes(w_wb, ID_RS2))              w_sel_b = FWD_HOLD;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_sel_a <= FWD_RF;
      r_sel_b <= FWD_RF;
    end else if (!EXT_HOLD) begin
      r_sel_a <= w_bubble ? FWD_RF : w_sel_a;
      r_sel_b <= w_bubble ? FWD_RF : w_sel_b;
    end
  end

  assign FWD_SEL_A = r_sel_a;
  assign FWD_SEL_B = r_sel_b;

endmodule
